// File: rtl/instr_enc_pkg.sv
// Shared constants and types for the RV32 instruction encoder.
package instr_enc_pkg;

    // Format select codes driven on fmt_i
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_CSR = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // Canonical NOP (addi x0, x0, 0), substituted for any word that fails its checks
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Major opcodes, instr[6:2] only (instr[1:0] is always 2'b11)
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    // Field bundle as captured by the first pipeline stage
    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_bundle_t;

endpackage

// File: rtl/imm_scatter.sv
// Places the immediate bits of one instruction format into their word
// positions and flags range/alignment violations. Purely combinational.
module imm_scatter
    import instr_enc_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [31:0] i_imm,
    output logic [31:0] o_imm_bits,
    output logic        o_err
);

    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX =  32'sd2047;
    localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
    localparam logic signed [31:0] IMMB_MAX  =  32'sd4094;
    localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
    localparam logic signed [31:0] IMMJ_MAX  =  32'sd1048574;

    logic signed [31:0] w_simm;
    assign w_simm = $signed(i_imm);

    // Scatter immediate bits per format and evaluate its range rule
    always_comb begin
        o_imm_bits = '0;
        o_err      = 1'b0;
        case (i_fmt)
            FMT_R: begin
                o_err = 1'b0;
            end
            FMT_I: begin
                o_imm_bits[31:20] = i_imm[11:0];
                o_err = (w_simm < IMM12_MIN) || (w_simm > IMM12_MAX);
            end
            FMT_S: begin
                o_imm_bits[31:25] = i_imm[11:5];
                o_imm_bits[11:7]  = i_imm[4:0];
                o_err = (w_simm < IMM12_MIN) || (w_simm > IMM12_MAX);
            end
            FMT_B: begin
                o_imm_bits[31]    = i_imm[12];
                o_imm_bits[30:25] = i_imm[10:5];
                o_imm_bits[11:8]  = i_imm[4:1];
                o_imm_bits[7]     = i_imm[11];
                o_err = (w_simm < IMMB_MIN) || (w_simm > IMMB_MAX) || i_imm[0];
            end
            FMT_U: begin
                o_imm_bits[31:12] = i_imm[31:12];
                o_err = (i_imm[11:0] != 12'd0);
            end
            FMT_J: begin
                o_imm_bits[31]    = i_imm[20];
                o_imm_bits[30:21] = i_imm[10:1];
                o_imm_bits[20]    = i_imm[11];
                o_imm_bits[19:12] = i_imm[19:12];
                o_err = (w_simm < IMMJ_MIN) || (w_simm > IMMJ_MAX) || i_imm[0];
            end
            FMT_CSR: begin
                // zimm occupies the rs1 slot
                o_imm_bits[19:15] = i_imm[4:0];
                o_err = (i_imm[31:5] != 27'd0);
            end
            default: begin
                o_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready encoder that assembles RV32 instruction words from
// field bundles; erroneous bundles come out as NOP with err_o set and are
// counted by a saturating counter at the output handshake.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           fmt_i,
    input  logic [4:0]           opcode_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    input  logic [31:0]          imm_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          instr_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                 r_vld_p1;
    enc_bundle_t          r_bnd_p1;
    logic                 r_vld_p2;
    logic [31:0]          r_instr_p2;
    logic                 r_err_p2;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_s1_adv;
    logic                 w_s2_adv;
    enc_bundle_t          w_bnd_in;
    logic [31:0]          w_imm_bits;
    logic                 w_imm_err;
    logic [31:0]          w_fields;
    logic [31:0]          w_enc;

    assign w_s2_adv   = !r_vld_p2 || out_ready_i;
    assign w_s1_adv   = !r_vld_p1 || w_s2_adv;
    assign in_ready_o = w_s1_adv;

    assign w_bnd_in = '{fmt: fmt_i, opcode: opcode_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i,
                        funct3: funct3_i, funct7: funct7_i, imm: imm_i};

    // ---- stage 1: capture the input bundle ----

    // S1 valid follows the input handshake whenever the stage may advance
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_adv) begin
            r_vld_p1 <= in_valid_i;
        end
    end

    // S1 payload is loaded only on an accepted bundle
    always_ff @(posedge clk_i) begin
        if (in_valid_i && w_s1_adv) begin
            r_bnd_p1 <= w_bnd_in;
        end
    end

    // ---- stage 2: encode and register the word ----

    imm_scatter u_imm_scatter (
        .i_fmt      (r_bnd_p1.fmt),
        .i_imm      (r_bnd_p1.imm),
        .o_imm_bits (w_imm_bits),
        .o_err      (w_imm_err)
    );

    // Register-field placement per format; immediate bits come from imm_scatter
    always_comb begin
        w_fields = '0;
        case (r_bnd_p1.fmt)
            FMT_R:          w_fields = {r_bnd_p1.funct7, r_bnd_p1.rs2, r_bnd_p1.rs1,
                                        r_bnd_p1.funct3, r_bnd_p1.rd, 7'd0};
            FMT_I:          w_fields = {12'd0, r_bnd_p1.rs1, r_bnd_p1.funct3,
                                        r_bnd_p1.rd, 7'd0};
            FMT_S, FMT_B:   w_fields = {7'd0, r_bnd_p1.rs2, r_bnd_p1.rs1,
                                        r_bnd_p1.funct3, 5'd0, 7'd0};
            FMT_U, FMT_J:   w_fields = {20'd0, r_bnd_p1.rd, 7'd0};
            FMT_CSR:        w_fields = {r_bnd_p1.funct7, r_bnd_p1.rs2, 5'd0,
                                        r_bnd_p1.funct3, r_bnd_p1.rd, 7'd0};
            default:        w_fields = '0;
        endcase
        w_enc = w_imm_err ? NOP
                          : (w_fields | w_imm_bits | {25'd0, r_bnd_p1.opcode, 2'b11});
    end

    // S2 holds its word while stalled and reloads on advance
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_vld_p2   <= 1'b0;
            r_instr_p2 <= '0;
            r_err_p2   <= 1'b0;
        end else if (w_s2_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_instr_p2 <= w_enc;
                r_err_p2   <= w_imm_err;
            end
        end
    end

    // Count erroneous words as they leave, holding at all-ones
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_err_cnt <= '0;
        end else if (r_vld_p2 && out_ready_i && r_err_p2) begin
            r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign out_valid_o = r_vld_p2;
    assign instr_o     = r_instr_p2;
    assign err_o       = r_err_p2;
    assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;
    import instr_enc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [4:0]  opcode, rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ERR_CNT_W(8)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .fmt_i       (fmt),
        .opcode_i    (opcode),
        .rd_i        (rd),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .funct3_i    (f3),
        .funct7_i    (f7),
        .imm_i       (imm),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .instr_o     (instr),
        .err_o       (err),
        .err_cnt_o   (err_cnt)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        eerr;
    } vec_t;

    task automatic set_bundle(input logic [2:0] t_fmt, input logic [4:0] t_op,
                              input logic [4:0] t_rd, input logic [4:0] t_rs1,
                              input logic [4:0] t_rs2, input logic [2:0] t_f3,
                              input logic [6:0] t_f7, input logic [31:0] t_imm);
        fmt = t_fmt; opcode = t_op; rd = t_rd; rs1 = t_rs1;
        rs2 = t_rs2; f3 = t_f3; f7 = t_f7; imm = t_imm;
    endtask

    task automatic test_reset();
        reset_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_bundle(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=00000000", instr); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", err); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL rst_err_cnt got=%h exp=00", err_cnt); end
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_formats();
        vec_t vt[17];
        logic rdy;
        vt[0]  = '{FMT_I,   OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0,   7'd0,   32'hFFFF_FFFF, 32'hFFF00093, 1'b0};
        vt[1]  = '{FMT_S,   OPC_STORE,  5'd0, 5'd1, 5'd2, 3'b010, 7'd0,   32'd12,        32'h0020A623, 1'b0};
        vt[2]  = '{FMT_B,   OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0,   7'd0,   32'd8,         32'h00000463, 1'b0};
        vt[3]  = '{FMT_B,   OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0,   7'd0,   32'd3,         32'h00000013, 1'b1};
        vt[4]  = '{FMT_U,   OPC_LUI,    5'd5, 5'd0, 5'd0, 3'd0,   7'd0,   32'h12345000,  32'h123452B7, 1'b0};
        vt[5]  = '{FMT_J,   OPC_JAL,    5'd1, 5'd0, 5'd0, 3'd0,   7'd0,   32'd2048,      32'h001000EF, 1'b0};
        vt[6]  = '{FMT_R,   OPC_OP,     5'd3, 5'd1, 5'd2, 3'd0,   7'd0,   32'hDEADBEEF,  32'h002081B3, 1'b0};
        vt[7]  = '{FMT_CSR, OPC_SYSTEM, 5'd1, 5'd7, 5'd5, 3'b101, 7'h18,  32'd5,         32'h3052D0F3, 1'b0};
        vt[8]  = '{FMT_I,   OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0,   7'd0,   32'd2048,      32'h00000013, 1'b1};
        vt[9]  = '{FMT_ILL, OPC_OP,     5'd3, 5'd1, 5'd2, 3'd0,   7'd0,   32'd0,         32'h00000013, 1'b1};
        vt[10] = '{FMT_B,   OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0,   7'd0,   32'hFFFFF000,  32'h80000063, 1'b0};
        vt[11] = '{FMT_J,   OPC_JAL,    5'd1, 5'd0, 5'd0, 3'd0,   7'd0,   32'hFFF00000,  32'h800000EF, 1'b0};
        vt[12] = '{FMT_U,   OPC_LUI,    5'd5, 5'd0, 5'd0, 3'd0,   7'd0,   32'h12345001,  32'h00000013, 1'b1};
        vt[13] = '{FMT_CSR, OPC_SYSTEM, 5'd1, 5'd0, 5'd5, 3'b101, 7'h18,  32'd32,        32'h00000013, 1'b1};
        vt[14] = '{FMT_B,   OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0,   7'd0,   32'd4094,      32'h7E000FE3, 1'b0};
        vt[15] = '{FMT_S,   OPC_STORE,  5'd0, 5'd0, 5'd0, 3'b010, 7'd0,   32'hFFFFF800,  32'h80002023, 1'b0};
        vt[16] = '{FMT_I,   OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0,   7'd0,   32'hFFFFF7FF,  32'h00000013, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            set_bundle(vt[i].fmt, vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].f3, vt[i].f7, vt[i].imm);
            in_valid = 1'b1;
            #1;
            rdy = in_ready;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL fmt_in_ready[%0d] got=%0b exp=1", i, rdy); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmt_early_valid[%0d] got=%0b exp=0", i, out_valid); end
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fmt_valid[%0d] got=%0b exp=1", i, out_valid); end
            checks++; if (instr !== vt[i].exp) begin errors++; $display("FAIL fmt_instr[%0d] got=%h exp=%h", i, instr, vt[i].exp); end
            checks++; if (err !== vt[i].eerr) begin errors++; $display("FAIL fmt_err[%0d] got=%0b exp=%0b", i, err, vt[i].eerr); end
        end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmt_drained got=%0b exp=0", out_valid); end
        checks++; if (err_cnt !== 8'd6) begin errors++; $display("FAIL fmt_err_cnt got=%0d exp=6", err_cnt); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int first_block = -1;
        logic rdy;
        logic have_hold = 1'b0;
        logic [31:0] held = '0;
        logic [31:0] exp_w;
        out_ready = 1'b0;
        fork
            begin
                for (int cyc = 0; cyc < 60 && sent < 6; cyc++) begin
                    @(negedge clk);
                    set_bundle(FMT_I, OPC_OP_IMM, 5'(sent + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(sent + 1));
                    in_valid = 1'b1;
                    #1;
                    rdy = in_ready;
                    if (!rdy && first_block < 0) first_block = sent;
                    @(posedge clk);
                    if (rdy) sent++;
                end
                #1;
                in_valid = 1'b0;
            end
            begin
                for (int cc = 0; cc < 60 && got < 6; cc++) begin
                    @(posedge clk);
                    #1;
                    out_ready = (cc >= 4);
                    @(negedge clk);
                    if (out_valid && !out_ready) begin
                        if (have_hold) begin
                            checks++; if (instr !== held) begin errors++; $display("FAIL bp_stable got=%h exp=%h", instr, held); end
                        end
                        held = instr;
                        have_hold = 1'b1;
                    end
                    if (out_valid && out_ready) begin
                        exp_w = (32'(got + 1) << 20) | (32'(got + 1) << 7) | 32'h13;
                        checks++; if (instr !== exp_w) begin errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", got, instr, exp_w); end
                        got++;
                    end
                end
            end
        join
        checks++; if (first_block != 2) begin errors++; $display("FAIL bp_first_block got=%0d exp=2", first_block); end
        checks++; if (sent != 6) begin errors++; $display("FAIL bp_sent got=%0d exp=6", sent); end
        checks++; if (got != 6) begin errors++; $display("FAIL bp_received got=%0d exp=6", got); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%0b exp=0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_bundle(FMT_I, OPC_OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
            in_valid = 1'b1;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got=%0b exp=1", out_valid); end
        checks++; if (err_cnt !== 8'd6) begin errors++; $display("FAIL mid_cnt_before got=%0d exp=6", err_cnt); end
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%0b exp=0", out_valid); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_cnt got=%0d exp=0", err_cnt); end
        @(negedge clk);
        reset_i = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard got=%0b exp=0", out_valid); end
        @(negedge clk);
        set_bundle(FMT_I, OPC_OP_IMM, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_lat1 got=%0b exp=0", out_valid); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_lat2 got=%0b exp=1", out_valid); end
        checks++; if (instr !== 32'h00900493) begin errors++; $display("FAIL mid_instr got=%h exp=00900493", instr); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        @(negedge clk);
        set_bundle(FMT_ILL, OPC_OP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        for (int n = 1; n <= 260; n++) begin
            @(posedge clk);
            if (n == 200) begin
                #1;
                checks++; if (err_cnt !== 8'd198) begin errors++; $display("FAIL sat_mid_cnt got=%0d exp=198", err_cnt); end
                checks++; if (err !== 1'b1 || instr !== NOP) begin errors++; $display("FAIL sat_word got=%h/%0b exp=%h/1", instr, err, NOP); end
            end
        end
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_cnt got=%h exp=ff", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_reset_midstream();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
